// File: rtl/rasterint_gen_pkg.sv
// rasterint_gen_pkg: timing-mode defaults and pulse FSM encoding shared by the raster interrupt block
package rasterint_gen_pkg;

    localparam int INT_TSTATES_48K    = 32;
    localparam int VRETRACE_LINE_48K  = 248;
    localparam int INT_HC_48K         = 0;

    localparam int INT_TSTATES_128K   = 36;
    localparam int VRETRACE_LINE_128K = 248;
    localparam int INT_HC_128K        = 0;

    localparam int INT_TSTATES_PENT   = 32;
    localparam int VRETRACE_LINE_PENT = 239;
    localparam int INT_HC_PENT        = 0;

    typedef enum logic {IDLE = 1'b0, PULSE = 1'b1} pulse_state_t;

    function automatic int timer_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rasterint_pulse.sv
// rasterint_pulse: /INT pulse timer, counts INT_TSTATES cpu_en ticks or ends early on ack
module rasterint_pulse
    import rasterint_gen_pkg::*;
#(
    parameter int INT_TSTATES = INT_TSTATES_48K
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic cpu_en,
    input  logic ack,
    output logic int_n,
    output logic busy
);

    localparam int TW = timer_width(INT_TSTATES);
    localparam logic [TW-1:0] LAST = TW'(INT_TSTATES - 1);

    pulse_state_t state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic expire;

    // state and T-state timer registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_d;
            timer <= timer_d;
        end
    end

    // starts are only taken from IDLE, so hits during a pulse (or on its last edge) are dropped
    always_comb begin
        expire  = cpu_en && (ack || timer == LAST);
        state_d = state == IDLE ? (start ? PULSE : IDLE) : (expire ? IDLE : PULSE);
        timer_d = (state == IDLE || expire) ? '0 : timer + TW'(cpu_en);
    end

    assign int_n = state == IDLE;
    assign busy  = state == PULSE;

endmodule

// File: rtl/rasterint_gen.sv
// rasterint_gen: raster/frame interrupt compare and Z80 /INT generation; RASTERINT_ACK_EN lets intack_n end the pulse early
module rasterint_gen
    import rasterint_gen_pkg::*;
#(
    parameter int HCW           = 9,
    parameter int VCW           = 9,
    parameter int INT_HC        = INT_HC_48K,
    parameter int VRETRACE_LINE = VRETRACE_LINE_48K,
    parameter int INT_TSTATES   = INT_TSTATES_48K
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pclk_en,
    input  logic           cpu_en,
    input  logic [HCW-1:0] hc,
    input  logic [VCW-1:0] vc,
    input  logic [8:0]     raster_line,
    input  logic           rasterint_enable,
    input  logic           vretraceint_disable,
    input  logic           intack_n,
    output logic           int_n,
    output logic           raster_int_in_progress
);

    logic [8:0] vc9;
    logic at_hc, vr_hit, rs_hit, ack, busy, raster_q;

    assign vc9    = 9'(vc);
    assign at_hc  = pclk_en && hc == HCW'(INT_HC);
    assign vr_hit = at_hc && vc == VCW'(VRETRACE_LINE) && !vretraceint_disable;
    assign rs_hit = at_hc && vc9 == raster_line && raster_line != 9'h1FF && rasterint_enable;

`ifdef RASTERINT_ACK_EN
    assign ack = !intack_n;
`else
    logic unused_intack;
    assign unused_intack = intack_n;
    assign ack = 1'b0;
`endif

    rasterint_pulse #(.INT_TSTATES(INT_TSTATES)) u_pulse (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (vr_hit || rs_hit),
        .cpu_en (cpu_en),
        .ack    (ack),
        .int_n  (int_n),
        .busy   (busy)
    );

    // remember whether the raster compare caused the pulse; frozen for the pulse duration
    always_ff @(posedge clk) begin
        if (!rst_n) raster_q <= 1'b0;
        else raster_q <= busy ? raster_q : rs_hit;
    end

    assign raster_int_in_progress = raster_q && busy;

endmodule

// File: tb/tb_rasterint_gen.sv
// tb_rasterint_gen: scoreboard bench for rasterint_gen pulse timing, source flag, retrigger, reset and ack
module tb_rasterint_gen;

    logic       clk = 0, rst_n = 0, pclk_en = 0, cpu_en = 0;
    logic [8:0] hc = 9'd5, vc = 9'd0, raster_line = 9'h1FF;
    logic       rasterint_enable = 0, vretraceint_disable = 1, intack_n = 1;
    logic       int_n, raster_int_in_progress;

    typedef struct {int start; int len; bit ip;} exp_t;
    exp_t sb[$];
    exp_t cur;
    int   cyc = 0, checks = 0, fails = 0, cnt = 0;
    bit   in_pulse = 0, ip_bad = 0;

    rasterint_gen dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .pclk_en                (pclk_en),
        .cpu_en                 (cpu_en),
        .hc                     (hc),
        .vc                     (vc),
        .raster_line            (raster_line),
        .rasterint_enable       (rasterint_enable),
        .vretraceint_disable    (vretraceint_disable),
        .intack_n               (intack_n),
        .int_n                  (int_n),
        .raster_int_in_progress (raster_int_in_progress)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // CPU T-state enable on every other clock
    initial forever begin
        @(posedge clk);
        #1 cpu_en = ~cpu_en;
    end

    // monitor: measure each low pulse and compare it against the next scoreboard entry
    always @(negedge clk) begin
        if (!int_n) begin
            if (!in_pulse) begin
                in_pulse = 1;
                cnt = 0;
                ip_bad = 0;
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_pulse: int_n=0 at cycle %0d, required 1", cyc);
                    cur = '{cyc, -1, 0};
                end else begin
                    cur = sb.pop_front();
                    if (cyc != cur.start) begin
                        fails++;
                        $display("FAIL pulse_start: int_n fell at cycle %0d, required %0d", cyc, cur.start);
                    end
                end
            end
            if (cpu_en) cnt++;
            if (raster_int_in_progress !== cur.ip) ip_bad = 1;
        end else if (in_pulse) begin
            in_pulse = 0;
            checks++;
            if (cnt != cur.len) begin
                fails++;
                $display("FAIL pulse_len: %0d T-states, required %0d", cnt, cur.len);
            end
            checks++;
            if (ip_bad || raster_int_in_progress !== 1'b0) begin
                fails++;
                $display("FAIL in_progress: flag deviated from %0d during pulse or is %0d after it, required 0", cur.ip, raster_int_in_progress);
            end
        end
    end

    task automatic hit(input logic [8:0] v, input bit expect_pulse, input int len, input bit ip);
        @(posedge clk);
        #1;
        if (expect_pulse) sb.push_back('{cyc + 1, len, ip});
        vc = v;
        hc = 9'd0;
        pclk_en = 1;
        @(posedge clk);
        #1;
        pclk_en = 0;
        hc = 9'd5;
    endtask

    task automatic wait_ticks(input int n);
        int t = 0;
        for (int i = 0; i < 400 && t < n; i++) begin
            @(negedge clk);
            if (!int_n && cpu_en) t++;
        end
        if (t < n) begin
            checks++;
            fails++;
            $display("FAIL wait_ticks: saw %0d T-states, required %0d", t, n);
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 400 && !int_n; i++) @(negedge clk);
        if (!int_n) begin
            checks++;
            fails++;
            $display("FAIL wait_idle: int_n=0 after 400 cycles, required 1");
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        checks++;
        if (int_n !== 1'b1 || raster_int_in_progress !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: int_n=%0d in_progress=%0d, required 1 0", int_n, raster_int_in_progress);
        end
        // frame interrupt
        vretraceint_disable = 0;
        hit(9'd248, 1, 32, 0);
        wait_idle();
        // raster interrupt on line 64
        vretraceint_disable = 1;
        raster_line = 9'h040;
        rasterint_enable = 1;
        hit(9'd64, 1, 32, 1);
        wait_idle();
        // coincident frame and raster hit: one pulse flagged as raster
        raster_line = 9'd248;
        vretraceint_disable = 0;
        hit(9'd248, 1, 32, 1);
        wait_idle();
        // both sources off: nothing
        vretraceint_disable = 1;
        rasterint_enable = 0;
        hit(9'd248, 0, 0, 0);
        repeat (40) @(posedge clk);
        // unreachable line across a full 312-line frame
        raster_line = 9'h1FF;
        rasterint_enable = 1;
        for (int l = 0; l < 312; l++) begin
            @(posedge clk);
            #1;
            vc = 9'(l);
            hc = 9'd0;
            pclk_en = 1;
        end
        @(posedge clk);
        #1;
        pclk_en = 0;
        hc = 9'd5;
        rasterint_enable = 0;
        repeat (40) @(posedge clk);
        // retrigger at T=10 and on the final edge are both ignored
        vretraceint_disable = 0;
        hit(9'd248, 1, 32, 0);
        wait_ticks(10);
        vc = 9'd248;
        hc = 9'd0;
        pclk_en = 1;
        @(posedge clk);
        #1;
        pclk_en = 0;
        hc = 9'd5;
        wait_ticks(22);
        hc = 9'd0;
        pclk_en = 1;
        @(posedge clk);
        #1;
        pclk_en = 0;
        hc = 9'd5;
        wait_idle();
        // reset at T=5 aborts the pulse; the next pulse is full length
        hit(9'd248, 1, 5, 0);
        wait_ticks(5);
        @(posedge clk);
        #1 rst_n = 0;
        @(posedge clk);
        #1 rst_n = 1;
        wait_idle();
        hit(9'd248, 1, 32, 0);
        wait_idle();
        // acknowledge on T=7
`ifdef RASTERINT_ACK_EN
        hit(9'd248, 1, 7, 0);
`else
        hit(9'd248, 1, 32, 0);
`endif
        wait_ticks(7);
        intack_n = 0;
        @(posedge clk);
        #1 intack_n = 1;
        wait_idle();
        for (int i = 0; i < 100 && (sb.size() != 0 || in_pulse); i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
